merge4_sync: RTL and testbench

Clocked 4-way merge: the collecting end of the 4-way steer. It takes four dual-rail channels (S, T, U, V) and a one-hot 4-bit steer token. It forwards the DATA wavefront of the token-selected channel onto a single dual-rail output, then runs the NULL return phase of the 4-phase NCL handshake on every side. It sits downstream of the steer stage, where the steered paths reconverge into one flow. It also provides a transfer counter and a sticky protocol-error flag.

---
 rtl/merge4_pkg.sv | 34 +++
 rtl/merge4_sync_dr_decode.sv | 20 ++
 rtl/merge4_sync.sv | 137 +++++++++++++
 tb/tb_merge4_sync.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/merge4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | merge4_pkg : shared types, dual-rail codes and token helpers       |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package merge4_pkg;

  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    DRIVE     = 2'd1,
    WAIT_NULL = 2'd2
  } state_e;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_D0   = 2'b01;
  localparam logic [1:0] DR_D1   = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Only meaningful when the argument is one-hot.
  function automatic logic [1:0] onehot_idx4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/merge4_sync_dr_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dr_decode : classifies one dual-rail pair as NULL / DATA / illegal |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module dr_decode
  import merge4_pkg::*;
(
  input  logic [1:0] rail_i,
  output logic       is_null_o,
  output logic       is_data_o,
  output logic       is_ill_o
);

  assign is_null_o = (rail_i == DR_NULL);
  assign is_data_o = (rail_i == DR_D0) || (rail_i == DR_D1);
  assign is_ill_o  = (rail_i == DR_ILL);

endmodule
`default_nettype wire

// File: rtl/merge4_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | merge4_sync : clocked 4-way dual-rail merge with NCL return phase  |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module merge4_sync
  import merge4_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             init,
  input  logic [1:0]       Ss,
  input  logic [1:0]       Ts,
  input  logic [1:0]       Us,
  input  logic [1:0]       Vs,
  output logic             SCOMP,
  output logic             TCOMP,
  output logic             UCOMP,
  output logic             VCOMP,
  input  logic [3:0]       steerin,
  output logic             steerinCOMP,
  output logic [1:0]       Z,
  input  logic             ZCOMP,
  output logic             err,
  output logic [CNT_W-1:0] xfer_count
);

  logic [1:0] rails [4];
  logic [3:0] is_null;
  logic [3:0] is_data;
  logic [3:0] is_ill;

  assign rails[0] = Ss;
  assign rails[1] = Ts;
  assign rails[2] = Us;
  assign rails[3] = Vs;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
      dr_decode u_dec (
        .rail_i    (rails[gi]),
        .is_null_o (is_null[gi]),
        .is_data_o (is_data[gi]),
        .is_ill_o  (is_ill[gi])
      );
    end
  endgenerate

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       z_q, z_d;
  logic [3:0]       comp_q, comp_d;
  logic             scomp_q, scomp_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       tok_onehot;
  logic [1:0] tok_idx;

  assign tok_onehot = is_onehot4(steerin);
  assign tok_idx    = onehot_idx4(steerin);

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q <= WAIT_DATA;
      sel_q   <= 2'd0;
      z_q     <= DR_NULL;
      comp_q  <= 4'b0000;
      scomp_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      z_q     <= z_d;
      comp_q  <= comp_d;
      scomp_q <= scomp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    z_d     = z_q;
    comp_d  = comp_q;
    scomp_d = scomp_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_DATA: begin
        // A held-high ZCOMP only stalls acceptance; token/channel faults still flag.
        if (steerin != 4'b0000) begin
          if (!tok_onehot || is_ill[tok_idx]) begin
            err_d = 1'b1;
          end else if (is_data[tok_idx] && !ZCOMP) begin
            sel_d   = tok_idx;
            z_d     = rails[tok_idx];
            state_d = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (ZCOMP) begin
          z_d     = DR_NULL;
          comp_d  = 4'b0001 << sel_q;
          scomp_d = 1'b1;
          state_d = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if ((steerin == 4'b0000) && is_null[sel_q] && !ZCOMP) begin
          comp_d  = 4'b0000;
          scomp_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = WAIT_DATA;
        end
      end
      default: begin
        state_d = WAIT_DATA;
      end
    endcase
  end

  assign Z           = z_q;
  assign SCOMP       = comp_q[0];
  assign TCOMP       = comp_q[1];
  assign UCOMP       = comp_q[2];
  assign VCOMP       = comp_q[3];
  assign steerinCOMP = scomp_q;
  assign err         = err_q;
  assign xfer_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_merge4_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_merge4_sync : directed + randomized transfers vs. a txn model   |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module tb_merge4_sync;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             init;
  logic [1:0]       Ss, Ts, Us, Vs;
  logic [3:0]       steerin;
  logic             ZCOMP;
  logic             SCOMP, TCOMP, UCOMP, VCOMP;
  logic             steerinCOMP;
  logic [1:0]       Z;
  logic             err;
  logic [CNT_W-1:0] xfer_count;

  int   checks = 0;
  int   errors = 0;
  int   m_cnt  = 0;
  logic m_err  = 1'b0;

  merge4_sync #(.CNT_W(CNT_W)) dut (
    .clk(clk), .init(init),
    .Ss(Ss), .Ts(Ts), .Us(Us), .Vs(Vs),
    .SCOMP(SCOMP), .TCOMP(TCOMP), .UCOMP(UCOMP), .VCOMP(VCOMP),
    .steerin(steerin), .steerinCOMP(steerinCOMP),
    .Z(Z), .ZCOMP(ZCOMP), .err(err), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp_z,
                             input logic [3:0] exp_comp, input logic exp_sc);
    chk({tag, "_Z"},     32'(Z), 32'(exp_z));
    chk({tag, "_COMP"},  32'({VCOMP, UCOMP, TCOMP, SCOMP}), 32'(exp_comp));
    chk({tag, "_TCOMP"}, 32'(steerinCOMP), 32'(exp_sc));
    chk({tag, "_err"},   32'(err), 32'(m_err));
    chk({tag, "_count"}, 32'(xfer_count), 32'(m_cnt % (1 << CNT_W)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ch(input int i, input logic [1:0] v);
    case (i)
      0: Ss = v;
      1: Ts = v;
      2: Us = v;
      default: Vs = v;
    endcase
  endtask

  task automatic idle_inputs();
    Ss = 2'b00; Ts = 2'b00; Us = 2'b00; Vs = 2'b00;
    steerin = 4'b0000; ZCOMP = 1'b0;
  endtask

  task automatic do_reset();
    init = 1'b1;
    idle_inputs();
    tick();
    m_cnt = 0;
    m_err = 1'b0;
    check_state("reset", 2'b00, 4'b0000, 1'b0);
    init = 1'b0;
  endtask

  // One full handshake; the model says Z must carry the selected channel's rails.
  task automatic xfer(input int idx, input logic [1:0] s, input logic [1:0] t,
                      input logic [1:0] u, input logic [1:0] v, input int hold);
    logic [1:0] c [4];
    logic [1:0] exp_z;
    logic [3:0] exp_comp;
    c = '{s, t, u, v};
    exp_z    = c[idx];
    exp_comp = 4'b0001 << idx;
    Ss = s; Ts = t; Us = u; Vs = v;
    steerin = 4'b0001 << idx;
    ZCOMP = 1'b0;
    tick();
    check_state("accept", exp_z, 4'b0000, 1'b0);
    Ss = 2'($urandom_range(0, 3)); Ts = 2'($urandom_range(0, 3));
    Us = 2'($urandom_range(0, 3)); Vs = 2'($urandom_range(0, 3));
    steerin = 4'($urandom_range(0, 15));
    ZCOMP = 1'b1;
    tick();
    check_state("complete", 2'b00, exp_comp, 1'b1);
    steerin = 4'b0001 << idx;
    drive_ch(idx, exp_z);
    ZCOMP = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check_state("hold", 2'b00, exp_comp, 1'b1);
    end
    steerin = 4'b0000;
    for (int i = 0; i < 4; i++) drive_ch(i, (i == idx) ? 2'b00 : 2'($urandom_range(0, 3)));
    tick();
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    check_state("release", 2'b00, 4'b0000, 1'b0);
  endtask

  task automatic rand_xfer();
    int         idx;
    logic [1:0] c [4];
    idx = $urandom_range(0, 3);
    for (int i = 0; i < 4; i++) c[i] = 2'($urandom_range(0, 3));
    c[idx] = 2'($urandom_range(1, 2));
    xfer(idx, c[0], c[1], c[2], c[3], $urandom_range(0, 2));
  endtask

  initial begin
    init = 1'b1;
    idle_inputs();
    tick();
    do_reset();

    // Basic T transfer.
    xfer(1, 2'b00, 2'b10, 2'b00, 2'b00, 0);

    // Downstream still requesting NULL: stall without error.
    Ss = 2'b01; steerin = 4'b0001; ZCOMP = 1'b1;
    tick();
    check_state("stall", 2'b00, 4'b0000, 1'b0);
    // Empty token, and token on a NULL channel: wait quietly.
    steerin = 4'b0000; ZCOMP = 1'b0;
    tick();
    check_state("no_token", 2'b00, 4'b0000, 1'b0);
    steerin = 4'b0100; Us = 2'b00;
    tick();
    check_state("sel_null", 2'b00, 4'b0000, 1'b0);

    // V selected with S also holding DATA; then S gets its turn.
    xfer(3, 2'b01, 2'b00, 2'b00, 2'b10, 1);
    xfer(0, 2'b01, 2'b00, 2'b00, 2'b10, 0);

    // Two-hot token.
    Ss = 2'b00; Ts = 2'b01; Us = 2'b10; Vs = 2'b00; steerin = 4'b0110;
    tick();
    m_err = 1'b1;
    check_state("two_hot", 2'b00, 4'b0000, 1'b0);
    steerin = 4'b0000;
    tick();
    check_state("err_sticky", 2'b00, 4'b0000, 1'b0);
    rand_xfer();
    rand_xfer();

    // Illegal rails on the selected channel.
    do_reset();
    Us = 2'b11; steerin = 4'b0100;
    check_state("pre_ill", 2'b00, 4'b0000, 1'b0);
    tick();
    m_err = 1'b1;
    check_state("sel_ill", 2'b00, 4'b0000, 1'b0);

    // 17 transfers on a 4-bit counter wrap back to 1.
    do_reset();
    for (int n = 0; n < 17; n++) rand_xfer();
    chk("wrap_count", 32'(xfer_count), 32'd1);
    chk("wrap_err", 32'(err), 32'd0);

    // Asynchronous reset while driving.
    rand_xfer();
    Ss = 2'b01; Ts = 2'b00; Us = 2'b00; Vs = 2'b00; steerin = 4'b0001; ZCOMP = 1'b0;
    tick();
    check_state("pre_async", 2'b01, 4'b0000, 1'b0);
    #2;
    init = 1'b1;
    #1;
    m_cnt = 0;
    m_err = 1'b0;
    check_state("async_rst", 2'b00, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    init = 1'b0;
    idle_inputs();
    tick();
    check_state("post_rst", 2'b00, 4'b0000, 1'b0);
    xfer(2, 2'b00, 2'b01, 2'b01, 2'b11, 0);

    // Randomized traffic with idle gaps.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        steerin = 4'b0000; ZCOMP = 1'b0;
        tick();
        check_state("gap", 2'b00, 4'b0000, 1'b0);
      end
      rand_xfer();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
